// File: rtl/qmac_accum.sv
// Accumulates a run of sign-magnitude fixed-point products into a wide two's
// complement sum, then presents it as a saturated sign-magnitude result.
module qmac_accum #(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_product,
    input  logic             i_ovr,
    output logic [N-1:0]     o_result,
    output logic             o_valid,
    input  logic             i_rdy,
    output logic             o_ovr,
    output logic             o_busy
);

    // Enough headroom for 2^CNT_W-1 full-scale terms, so the sum itself never wraps.
    localparam int ACC_W = N + CNT_W;

    if (Q > N - 1) begin : g_q_check
        $error("qmac_accum: Q must not exceed N-1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [N-1:0]            result_reg;
    logic                    valid_reg;
    logic                    ready_reg;
    logic                    busy_reg;
    logic                    ovr_reg;

    logic                    accept;
    logic                    last_accept;
    logic signed [ACC_W-1:0] prod_mag_ext;
    logic signed [ACC_W-1:0] prod_tc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] sum_abs;
    logic                    sum_neg;
    logic                    sum_sat;
    logic [N-2:0]            sum_mag;
    logic [N-1:0]            result_next;

    assign accept      = ready_reg & i_valid;
    assign last_accept = accept && (count_reg == CNT_W'(1));

    // Negative zero on input negates to zero, so it contributes nothing.
    assign prod_mag_ext = {{(CNT_W + 1){1'b0}}, i_product[N-2:0]};
    assign prod_tc      = i_product[N-1] ? -prod_mag_ext : prod_mag_ext;
    assign acc_sum      = acc_reg + prod_tc;

    // Sign is taken from the two's complement sum, so a zero sum is never negative.
    assign sum_neg     = acc_sum[ACC_W-1];
    assign sum_abs     = sum_neg ? -acc_sum : acc_sum;
    assign sum_sat     = |sum_abs[ACC_W-1:N-1];
    assign sum_mag     = sum_sat ? {(N - 1){1'b1}} : sum_abs[N-2:0];
    assign result_next = {sum_neg, sum_mag};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        ovr_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (i_len == '0) begin
                            result_reg <= '0;
                            valid_reg  <= 1'b1;
                            state_reg  <= OUT;
                        end else begin
                            acc_reg   <= '0;
                            count_reg <= i_len;
                            ready_reg <= 1'b1;
                            state_reg <= ACC;
                        end
                    end
                end

                ACC: begin
                    if (accept) begin
                        acc_reg   <= acc_sum;
                        count_reg <= count_reg - CNT_W'(1);
                        ovr_reg   <= ovr_reg | i_ovr | (last_accept & sum_sat);
                        if (last_accept) begin
                            result_reg <= result_next;
                            ready_reg  <= 1'b0;
                            valid_reg  <= 1'b1;
                            state_reg  <= OUT;
                        end
                    end
                end

                OUT: begin
                    // A start arriving with the handshake is dropped; it must come in IDLE.
                    if (i_rdy) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_reg;
    assign o_valid  = valid_reg;
    assign o_busy   = busy_reg;
    assign o_ovr    = ovr_reg;
    assign o_result = result_reg;

endmodule

// File: doc/qmac_accum.md
QMAC_ACCUM -- requirements
Module: qmac_accum

Interface
REQ-001 SHALL have parameter Q, default 15, fractional bits of every operand and result.
REQ-002 SHALL have parameter N, default 32, total word width: bit N-1 is sign, bits N-2:0 are magnitude.
REQ-003 SHALL have parameter CNT_W, default 8, width of the term-count input.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  begins one accumulation job.
REQ-007 SHALL have port i_len  input  CNT_W  number of products in the job; sampled with i_start.
REQ-008 SHALL have port i_valid  input  1  i_product and i_ovr are valid.
REQ-009 SHALL have port o_ready  output  1  block accepts a product this cycle.
REQ-010 SHALL have port i_product  input  N  sign-magnitude Q(N,Q) product from the upstream fixed-point multiplier.
REQ-011 SHALL have port i_ovr  input  1  upstream multiplier overflow flag for i_product.
REQ-012 SHALL have port o_result  output  N  sign-magnitude Q(N,Q) sum, registered.
REQ-013 SHALL have port o_valid  output  1  o_result holds a finished sum.
REQ-014 SHALL have port i_rdy  input  1  downstream consumes o_result.
REQ-015 SHALL have port o_ovr  output  1  sticky overflow for the current/last job.
REQ-016 SHALL have port o_busy  output  1  high in ACC and OUT states.

Function
REQ-017 SHALL implement states IDLE, ACC, OUT; o_ready=1 only in ACC; o_valid=1 only in OUT; o_busy=1 in ACC and OUT.
REQ-018 IDLE, i_start=1, i_len!=0: SHALL clear accumulator and o_ovr, load count=i_len, enter ACC next cycle.
REQ-019 IDLE, i_start=1, i_len=0: SHALL clear o_ovr, set o_result=0, enter OUT next cycle.
REQ-020 i_start outside IDLE SHALL be ignored.
REQ-021 A product SHALL be accepted exactly when i_valid=1 and o_ready=1 on a rising edge; i_valid without o_ready has no effect.
REQ-022 Accept: SHALL convert i_product to two's complement (sign? -mag : mag) and add to an (N+CNT_W)-bit signed accumulator; binary point unchanged (no shift).
REQ-023 Accept: SHALL decrement count; if i_ovr=1, SHALL set o_ovr.
REQ-024 Accept with count=1: SHALL register converted result into o_result and enter OUT; o_valid rises the cycle after the last accept (latency 1).
REQ-025 Conversion: magnitude > 2^(N-1)-1 SHALL saturate to 2^(N-1)-1 with sign kept, and set o_ovr.
REQ-026 Zero sum SHALL be output as all-zero (no negative zero); input negative zero SHALL add 0.
REQ-027 OUT: o_result and o_valid SHALL hold until i_rdy=1; then IDLE next cycle, o_valid=0.
REQ-028 OUT, i_rdy=1 and i_start=1 same cycle: start SHALL be ignored; a new job requires i_start in IDLE.
REQ-029 o_result and o_ovr SHALL remain stable in IDLE until next i_start.

Reset
REQ-030 i_rst_n=0 SHALL immediately force IDLE, accumulator=0, count=0, o_result=0, o_valid=0, o_ready=0, o_ovr=0, o_busy=0, regardless of clock.
REQ-031 Reset mid-job SHALL discard the partial sum; first start after release SHALL behave as a fresh job.

Verification
REQ-032 i_len=3; products +1.0 (0x00008000), +0.5 (0x00004000), -0.25 (0x80002000) -> o_result=0x0000A000 (+1.25), o_valid one cycle after third accept, o_ovr=0.
REQ-033 i_len=2; +0.5 then -0.5 -> o_result=0x00000000, sign bit 0.
REQ-034 i_len=2; 0x7FFFFFFF twice -> o_result=0x7FFFFFFF, o_ovr=1; same with 0xFFFFFFFF -> 0xFFFFFFFF, o_ovr=1.
REQ-035 i_len=0 -> o_valid next cycle, o_result=0; i_rdy held low 5 cycles -> o_valid/o_result hold; i_rdy=1 -> IDLE.
REQ-036 i_len=4, i_valid toggled randomly, one product with i_ovr=1 -> exactly 4 accepts, correct sum, o_ovr=1.
REQ-037 Reset asserted after 2 of 4 accepts, then job i_len=1 with +0.5 -> o_result=0x00004000.
